// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: loads a cipher key, then emits one round key per accepted advance, rounds 0..NR.
// Optional AES_KEY_LAST_CAPTURE_EN adds last_key, holding the final round key for decryption start.
module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round,
  output logic         key_valid,
  output logic         done
`ifdef AES_KEY_LAST_CAPTURE_EN
  ,
  output logic [127:0] last_key
`endif
);

  localparam logic [3:0] LAST = 4'(NR);

  // Byte 0 sits in the most significant byte, so byte x is at bit offset {~x, 3'b000}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_nxt;
  logic [7:0]   rcon;
  logic [31:0]  w0, w1, w2, w3, rot, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] key_nxt;
  logic         adv;

  always_comb begin
    {w0, w1, w2, w3} = round_key;
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    key_nxt = {n0, n1, n2, n3};
  end

  assign adv = !start && (state == RUN) && next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)                     state_nxt = RUN;
    else if (adv && round == LAST) state_nxt = IDLE;
  end

  always_comb begin
    key_valid = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_key <= '0;
      round     <= '0;
      rcon      <= 8'h01;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        round_key <= key_in;
        round     <= '0;
        rcon      <= 8'h01;
      end else if (adv) begin
        if (round < LAST) begin
          round_key <= key_nxt;
          round     <= round + 4'd1;
          rcon      <= xtime(rcon);
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

`ifdef AES_KEY_LAST_CAPTURE_EN
  // Captured only when the final round key is produced; a reload leaves it intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                last_key <= '0;
    else if (adv && round == LAST - 4'd1)   last_key <= key_nxt;
  end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key schedule vectors.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         next;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic         key_valid;
  logic         done;
`ifdef AES_KEY_LAST_CAPTURE_EN
  logic [127:0] last_key;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .next      (next),
    .round_key (round_key),
    .round     (round),
    .key_valid (key_valid),
    .done      (done)
`ifdef AES_KEY_LAST_CAPTURE_EN
    ,
    .last_key  (last_key)
`endif
  );

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } vec_t;

  vec_t tab[11];

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
    key_in = '0;
  endtask

  initial begin
    tab[0]  = '{4'd0,  KEY_A1};
    tab[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    tab[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    tab[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    tab[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    tab[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    tab[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    tab[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    tab[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    tab[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    rst = 1'b1; start = 1'b0; key_in = '0; next = 1'b0;
    tick();
    chk("reset_valid", 128'(key_valid), 128'(0));
    chk("reset_round", 128'(round), 128'(0));
    chk("reset_key",   round_key, 128'h0);
    chk("reset_done",  128'(done), 128'(0));

    // next is ignored while idle
    rst = 1'b0;
    next = 1'b1;
    tick();
    chk("idle_next_valid", 128'(key_valid), 128'(0));
    next = 1'b0;

    do_start(KEY_A1);
    chk("load_round", 128'(round), 128'(tab[0].rnd));
    chk("load_key",   round_key, tab[0].key);
    chk("load_valid", 128'(key_valid), 128'(1));

    next = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("a1_round%0d_idx", i), 128'(round), 128'(tab[i].rnd));
      chk($sformatf("a1_round%0d_key", i), round_key, tab[i].key);
      chk($sformatf("a1_round%0d_valid", i), 128'(key_valid), 128'(1));
      chk($sformatf("a1_round%0d_done", i), 128'(done), 128'(0));
    end

    tick();
    chk("end_valid", 128'(key_valid), 128'(0));
    chk("end_done",  128'(done), 128'(1));
    chk("end_round", 128'(round), 128'(10));
    chk("end_key",   round_key, tab[10].key);
    tick();
    chk("after_done",  128'(done), 128'(0));
    chk("after_valid", 128'(key_valid), 128'(0));
    chk("after_round", 128'(round), 128'(10));
    next = 1'b0;
`ifdef AES_KEY_LAST_CAPTURE_EN
    chk("last_key_a1", last_key, tab[10].key);
`endif

    // Stall at round 3, then reload mid-run at round 6 with next still high
    do_start(KEY_A1);
    next = 1'b1;
    repeat (3) tick();
    next = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d_round", i), 128'(round), 128'(3));
      chk($sformatf("stall%0d_key", i), round_key, tab[3].key);
    end
    next = 1'b1;
    repeat (3) tick();
    chk("pre_reload_round", 128'(round), 128'(6));
    chk("pre_reload_key",   round_key, tab[6].key);
    do_start(KEY_C1);
    chk("reload_round", 128'(round), 128'(0));
    chk("reload_key",   round_key, KEY_C1);
    chk("reload_done",  128'(done), 128'(0));
    chk("reload_valid", 128'(key_valid), 128'(1));
`ifdef AES_KEY_LAST_CAPTURE_EN
    chk("last_key_after_start", last_key, tab[10].key);
`endif
    tick();
    chk("c1_round1_idx", 128'(round), 128'(1));
    chk("c1_round1_key", round_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

    // Reset asserted between edges while at round 4
    do_start(KEY_A1);
    repeat (4) tick();
    next = 1'b0;
    chk("prerst_round", 128'(round), 128'(4));
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 128'(key_valid), 128'(0));
    chk("midrst_round", 128'(round), 128'(0));
    chk("midrst_key",   round_key, 128'h0);
    chk("midrst_done",  128'(done), 128'(0));
`ifdef AES_KEY_LAST_CAPTURE_EN
    chk("midrst_last_key", last_key, 128'h0);
`endif
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_done",  128'(done), 128'(0));
    chk("postrst_valid", 128'(key_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
